// File: rtl/wb_avm_bridge.sv
// rtl/wb_avm_bridge.sv - XBUS (pipelined Wishbone) to Avalon-MM bridge with window check and stall timeout
module wb_avm_bridge #(
  parameter logic [31:0] BASE_ADDR      = 32'h8000_0000,
  parameter logic [31:0] ADDR_MASK      = 32'hF000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        avm_cs_o,
  output logic [31:0] avm_address_o,
  output logic        avm_read_o,
  output logic        avm_write_o,
  output logic [31:0] avm_writedata_o,
  output logic [3:0]  avm_byteenable_o,
  input  logic        avm_waitrequest_i,
  input  logic [31:0] avm_readdata_i
);

  typedef enum logic [1:0] {IDLE, BUSY, ACK, ERR} state_t;

  // Counter value on the last permitted wait cycle; the counter is only
  // consulted when the timeout is enabled, so the TIMEOUT_CYCLES=0 wrap is harmless.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);

  state_t      state_q, state_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] wdat_q, wdat_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d;
  logic [31:0] rdat_q, rdat_d;
  logic [15:0] cnt_q, cnt_d;
  logic        abort_q, abort_d;

  logic in_win;
  logic cyc_gone;

  assign in_win   = ((wb_adr_i & ADDR_MASK) == BASE_ADDR);
  // Master has walked away from this access (now or earlier in BUSY).
  assign cyc_gone = abort_q | ~wb_cyc_i;

  // State and request registers; reset returns everything to idle zeros.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q <= IDLE;
      adr_q   <= '0;
      wdat_q  <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      rdat_q  <= '0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      rdat_q  <= rdat_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
    end
  end

  // Next-state logic: accept in IDLE, hold the Avalon access in BUSY, one-cycle ACK/ERR.
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    rdat_d  = rdat_q;
    cnt_d   = cnt_q;
    abort_d = abort_q;
    case (state_q)
      IDLE: begin
        if (wb_stb_i && wb_cyc_i) begin
          if (in_win) begin
            adr_d   = {wb_adr_i[31:2], 2'b00};
            wdat_d  = wb_dat_i;
            sel_d   = wb_sel_i;
            we_d    = wb_we_i;
            cnt_d   = '0;
            abort_d = 1'b0;
            state_d = BUSY;
          end else begin
            state_d = ERR;
          end
        end
      end
      BUSY: begin
        if (!wb_cyc_i) begin
          abort_d = 1'b1;
        end
        if (!avm_waitrequest_i) begin
          if (!we_q) begin
            rdat_d = avm_readdata_i;
          end
          state_d = cyc_gone ? IDLE : ACK;
        end else begin
          if (cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
          end
          if (TO_EN && (cnt_q == TO_LAST)) begin
            state_d = cyc_gone ? IDLE : ERR;
          end
        end
      end
      ACK:     state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign avm_cs_o         = (state_q == BUSY);
  assign avm_read_o       = (state_q == BUSY) & ~we_q;
  assign avm_write_o      = (state_q == BUSY) & we_q;
  assign avm_address_o    = adr_q;
  assign avm_writedata_o  = wdat_q;
  assign avm_byteenable_o = sel_q;
  assign wb_ack_o         = (state_q == ACK);
  assign wb_err_o         = (state_q == ERR);
  assign wb_dat_o         = rdat_q;

endmodule

// File: tb/tb_wb_avm_bridge.sv
// tb/tb_wb_avm_bridge.sv - self-checking bench for wb_avm_bridge
module tb_wb_avm_bridge;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wb_adr, wb_dat_w, wb_dat_r;
  logic        wb_we, wb_stb, wb_cyc, wb_ack, wb_err;
  logic [3:0]  wb_sel;
  logic        avm_cs, avm_rd, avm_wr, avm_wait;
  logic [31:0] avm_adr, avm_wd, avm_rdata;
  logic [3:0]  avm_be;

  int total  = 0;
  int passed = 0;
  logic [31:0] last_rd = 32'h0;

  wb_avm_bridge #(
    .BASE_ADDR(32'h8000_0000), .ADDR_MASK(32'hF000_0000), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_clk(clk), .reset_reset(rst),
    .wb_adr_i(wb_adr), .wb_dat_i(wb_dat_w), .wb_we_i(wb_we), .wb_sel_i(wb_sel),
    .wb_stb_i(wb_stb), .wb_cyc_i(wb_cyc), .wb_dat_o(wb_dat_r),
    .wb_ack_o(wb_ack), .wb_err_o(wb_err),
    .avm_cs_o(avm_cs), .avm_address_o(avm_adr), .avm_read_o(avm_rd),
    .avm_write_o(avm_wr), .avm_writedata_o(avm_wd), .avm_byteenable_o(avm_be),
    .avm_waitrequest_i(avm_wait), .avm_readdata_i(avm_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One XBUS access against an Avalon slave that stalls for 'stalls' cycles.
  // Expected behaviour comes from the window rule, the latency rules and the
  // timeout limit, not from the bridge's internal state.
  task automatic access(input logic [31:0] adr, input logic [31:0] dat, input logic we,
                        input logic [3:0] sel, input int stalls, input logic [31:0] rdata);
    logic in_win;
    bit   done;
    in_win = ((adr & 32'hF000_0000) == 32'h8000_0000);
    wb_adr = adr; wb_dat_w = dat; wb_we = we; wb_sel = sel;
    wb_stb = 1'b1; wb_cyc = 1'b1; avm_wait = 1'b1;
    next_cycle();
    wb_stb = 1'b0;
    if (!in_win) begin
      @(negedge clk);
      chk("oow_err", {31'b0, wb_err}, 32'd1);
      chk("oow_ack", {31'b0, wb_ack}, 32'd0);
      chk("oow_cs", {31'b0, avm_cs}, 32'd0);
      chk("oow_dat_hold", wb_dat_r, last_rd);
      next_cycle();
      wb_cyc = 1'b0;
      @(negedge clk);
      chk("oow_err_once", {31'b0, wb_err}, 32'd0);
    end else begin
      done = 1'b0;
      for (int k = 0; k < 20 && !done; k++) begin
        avm_wait  = (k < stalls);
        avm_rdata = rdata;
        @(negedge clk);
        chk("busy_cs", {31'b0, avm_cs}, 32'd1);
        chk("busy_rd", {31'b0, avm_rd}, {31'b0, ~we});
        chk("busy_wr", {31'b0, avm_wr}, {31'b0, we});
        chk("busy_adr", avm_adr, adr & 32'hFFFF_FFFC);
        chk("busy_wd", avm_wd, dat);
        chk("busy_be", {28'b0, avm_be}, {28'b0, sel});
        chk("busy_noack", {30'b0, wb_ack, wb_err}, 32'd0);
        if (avm_wait && k == TO - 1) begin
          next_cycle();
          @(negedge clk);
          chk("to_err", {31'b0, wb_err}, 32'd1);
          chk("to_ack", {31'b0, wb_ack}, 32'd0);
          chk("to_cs", {31'b0, avm_cs}, 32'd0);
          chk("to_dat_hold", wb_dat_r, last_rd);
          done = 1'b1;
        end else if (!avm_wait) begin
          next_cycle();
          if (!we) last_rd = rdata;
          @(negedge clk);
          chk("ack", {31'b0, wb_ack}, 32'd1);
          chk("ack_err", {31'b0, wb_err}, 32'd0);
          chk("ack_cs", {31'b0, avm_cs}, 32'd0);
          chk("ack_dat", wb_dat_r, last_rd);
          done = 1'b1;
        end else begin
          next_cycle();
        end
      end
      if (!done) chk("access_bound", 32'd0, 32'd1);
      #1;
      wb_cyc = 1'b0; avm_wait = 1'b1;
    end
  endtask

  initial begin
    logic [31:0] a, d, r;
    rst = 1'b1; wb_adr = '0; wb_dat_w = '0; wb_we = 1'b0; wb_sel = '0;
    wb_stb = 1'b0; wb_cyc = 1'b0; avm_wait = 1'b1; avm_rdata = '0;
    repeat (3) next_cycle();
    @(negedge clk);
    chk("rst_outs", {27'b0, wb_ack, wb_err, avm_cs, avm_rd, avm_wr}, 32'd0);
    chk("rst_dat", wb_dat_r, 32'd0);
    chk("rst_adr", avm_adr, 32'd0);
    next_cycle();
    rst = 1'b0;
    next_cycle();

    // Directed cases
    access(32'h8000_0104, 32'h0, 1'b0, 4'hF, 0, 32'hDEAD_BEEF);
    next_cycle();
    access(32'h8000_0020, 32'h1234_5678, 1'b1, 4'b0011, 3, 32'hFFFF_FFFF);
    next_cycle();
    access(32'h4000_0000, 32'h0, 1'b0, 4'hF, 0, 32'h0);
    next_cycle();
    access(32'h8000_0040, 32'h0, 1'b0, 4'hF, 100, 32'h5555_AAAA);
    next_cycle();
    access(32'h8000_0044, 32'h0, 1'b0, 4'hF, 0, 32'hA5A5_0001);
    next_cycle();
    access(32'h8000_0003, 32'h0, 1'b0, 4'hF, 0, 32'h0BAD_F00D);
    next_cycle();
    access(32'h8000_0008, 32'h0, 1'b0, 4'hF, 1, 32'h1111_2222);
    next_cycle();

    // cyc dropped mid-stall: access finishes on Avalon, no ack
    wb_adr = 32'h8000_0200; wb_we = 1'b0; wb_sel = 4'hF;
    wb_stb = 1'b1; wb_cyc = 1'b1; avm_wait = 1'b1;
    next_cycle();
    wb_stb = 1'b0;
    @(negedge clk);
    chk("drop_cs0", {31'b0, avm_cs}, 32'd1);
    next_cycle();
    wb_cyc = 1'b0;
    @(negedge clk);
    chk("drop_cs1", {31'b0, avm_cs}, 32'd1);
    next_cycle();
    avm_wait = 1'b0; avm_rdata = 32'hC0DE_0001;
    @(negedge clk);
    chk("drop_rd", {31'b0, avm_rd}, 32'd1);
    next_cycle();
    avm_wait = 1'b1;
    last_rd = 32'hC0DE_0001;
    @(negedge clk);
    chk("drop_noack", {29'b0, wb_ack, wb_err, avm_cs}, 32'd0);
    next_cycle();
    @(negedge clk);
    chk("drop_noack2", {29'b0, wb_ack, wb_err, avm_cs}, 32'd0);
    next_cycle();

    // reset asserted during a stalled BUSY
    wb_adr = 32'h8000_0300; wb_we = 1'b1; wb_dat_w = 32'h7777_8888;
    wb_stb = 1'b1; wb_cyc = 1'b1; avm_wait = 1'b1;
    next_cycle();
    wb_stb = 1'b0;
    next_cycle();
    rst = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("midrst_outs", {27'b0, wb_ack, wb_err, avm_cs, avm_rd, avm_wr}, 32'd0);
    chk("midrst_dat", wb_dat_r, 32'd0);
    chk("midrst_be", {28'b0, avm_be}, 32'd0);
    last_rd = 32'h0;
    next_cycle();
    rst = 1'b0; wb_cyc = 1'b0;
    next_cycle();

    // Randomized accesses
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 4) != 0)
        a = 32'h8000_0000 | ($urandom & 32'h0FFF_FFFF);
      else
        a = {4'($urandom_range(0, 7)), 28'($urandom)};
      d = $urandom;
      r = $urandom;
      access(a, d, 1'($urandom), 4'($urandom), $urandom_range(0, 10), r);
      next_cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/wb_avm_bridge.md
Name: wb_avm_bridge

Overview:
- Bridges the NEORV32 external bus (XBUS, pipelined Wishbone, single outstanding access) to the Avalon-MM slave port of the Qsys core, which holds the SDRAM controller and SPI master.
- Registers one request, drives it on the Avalon side until waitrequest releases, then returns ack with read data to the CPU.
- Rejects accesses outside its window with err.
- Aborts an access that stalls for longer than a programmable number of cycles.

Parameters:
- BASE_ADDR, 32'h8000_0000, start of the accepted address window.
- ADDR_MASK, 32'hF000_0000, address bits compared against BASE_ADDR.
- TIMEOUT_CYCLES, 255, maximum number of Avalon wait cycles before abort; 0 disables the timeout.

Ports:
- clk_clk  in  1  system clock; all logic is on the rising edge.
- reset_reset  in  1  synchronous, active-high reset.
- wb_adr_i  in  32  byte address.
- wb_dat_i  in  32  write data.
- wb_we_i  in  1  1=write, 0=read.
- wb_sel_i  in  4  byte enables.
- wb_stb_i  in  1  request strobe, one-cycle pulse.
- wb_cyc_i  in  1  cycle valid; held high for the whole access.
- wb_dat_o  out  32  read data, valid when wb_ack_o=1.
- wb_ack_o  out  1  one-cycle completion pulse.
- wb_err_o  out  1  one-cycle error pulse.
- avm_cs_o  out  1  Avalon chip select.
- avm_address_o  out  32  Avalon byte address, word-aligned (bits [1:0]=0).
- avm_read_o  out  1  Avalon read.
- avm_write_o  out  1  Avalon write.
- avm_writedata_o  out  32  Avalon write data.
- avm_byteenable_o  out  4  Avalon byte enables.
- avm_waitrequest_i  in  1  slave stall.
- avm_readdata_i  in  32  read data, valid in the cycle avm_waitrequest_i=0 during a read.

Behaviour:
- Reset: all outputs are 0, wb_dat_o=0, state=IDLE, timeout counter=0. A synchronous reset in any state returns to IDLE on the next edge. It immediately drops avm_cs_o, avm_read_o and avm_write_o; no ack or err is issued.
- IDLE:
  - The bridge accepts a request on wb_stb_i & wb_cyc_i.
  - In window ((wb_adr_i & ADDR_MASK) == BASE_ADDR): the bridge latches the address (bits [1:0] forced to 0), data, sel and we. It goes to BUSY.
  - Out of window: go to ERR. The Avalon side stays idle.
  - wb_stb_i without wb_cyc_i is ignored.
- BUSY:
  - avm_cs_o=1, plus avm_read_o=~we or avm_write_o=we. The address, writedata and byteenable outputs stay stable for the whole state.
  - The first BUSY cycle is the cycle after stb is accepted.
  - When avm_waitrequest_i=0, the transfer completes in that cycle. For reads, avm_readdata_i is captured into wb_dat_o. Go to ACK.
  - Otherwise the timeout counter increments. When it reaches TIMEOUT_CYCLES with waitrequest still 1, go to ERR and drop the Avalon strobes.
- ACK: wb_ack_o=1 for exactly one cycle, Avalon strobes are 0, then go to IDLE. Minimum latency is stb accepted at cycle N, ack at cycle N+2.
- ERR: wb_err_o=1 for exactly one cycle, then go to IDLE. Out-of-window latency is err at N+1.
- wb_dat_o holds its last value until the next read completes. It is not cleared on writes or err.
- wb_cyc_i dropped while in BUSY:
  - The Avalon access still completes; it is never abandoned mid-transfer except by timeout.
  - The bridge then returns to IDLE without an ack pulse.
  - A new stb is accepted only in IDLE. Strobes arriving in BUSY, ACK or ERR are ignored, because XBUS has a single outstanding access.
- The timeout counter is 16 bits wide. It clears on every entry to BUSY and saturates without wrapping. If TIMEOUT_CYCLES=0, the counter never aborts.
- ack and err are never asserted in the same cycle.

Test Plan:
- Read with no stall, waitrequest=0 throughout: stb at cycle 0 with adr=0x8000_0104 → avm_read_o=1 and address=0x8000_0104 at cycle 1; readdata=0xDEADBEEF is captured; ack at cycle 2 with wb_dat_o=0xDEADBEEF.
- Write with 3 stall cycles: wb_sel_i=4'b0011, wb_dat_i=0x1234_5678 → avm_write_o, writedata and byteenable stay stable for 4 cycles; ack arrives 1 cycle after waitrequest falls; avm_read_o is never asserted.
- Out-of-window read at adr=0x4000_0000 → avm_cs_o never asserted; wb_err_o pulses at cycle 1; no ack.
- Timeout with TIMEOUT_CYCLES=8 and waitrequest held at 1 → strobes drop after 8 wait cycles; a single err pulse follows; the next read completes normally.
- Abort and reset cases:
  - wb_cyc_i deasserted during a stall, then waitrequest released → the Avalon access completes and no ack is issued.
  - reset_reset asserted mid-BUSY → all outputs are 0 on the next edge.
- Misaligned address adr=0x8000_0003 → avm_address_o=0x8000_0000; back-to-back reads separated by one idle cycle both ack with the correct data.
